game_ctrl: RTL and testbench

- Top-level game sequencer for the dinosaur runner.
- Turns player buttons and the collision flag into run/pause/over control.
- Drives the start/pause inputs of the score counter and issues a restart clear.
- Schedules scroll speed from the live score and keeps the session high score.
- Sits between the input synchronisers and the score, obstacle and render blocks, on the frame clock.

---
 rtl/game_ctrl_pkg.sv | 20 ++
 rtl/game_ctrl_btn_edge.sv | 19 +
 rtl/game_ctrl.sv | 139 +++++++++++++
 tb/tb_game_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared state encodings and default constants for the dinosaur runner.
// Render and obstacle blocks import this to decode state and speed.
package game_ctrl_pkg;

   typedef enum logic [1:0] {
      GS_IDLE   = 2'd0,
      GS_RUN    = 2'd1,
      GS_PAUSED = 2'd2,
      GS_OVER   = 2'd3
   } gstate_e;

   localparam int GC_SCORELEN  = 9;
   localparam int GC_SCORE_W   = GC_SCORELEN + 1;
   localparam int GC_SPD_W     = 4;
   localparam int GC_SPD_BASE  = 1;
   localparam int GC_SPD_MAX   = 8;
   localparam int GC_SPD_STEP  = 50;
   localparam int GC_OVER_HOLD = 30;

endpackage

// File: rtl/game_ctrl_btn_edge.sv
// Rising-edge detector; the previous-value register resets high so a
// button held through reset does not produce an edge.
module btn_edge (
   input  logic clk3,
   input  logic reset,
   input  logic btn_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk3 or posedge reset) begin
      if (reset) prev_q <= 1'b1;
      else       prev_q <= btn_i;
   end

   assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: run/pause/over control, restart clear, speed
// scheduling from the live score and session high score.
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int SCORE_W   = GC_SCORE_W,
   parameter int SPD_W     = GC_SPD_W,
   parameter int SPD_BASE  = GC_SPD_BASE,
   parameter int SPD_MAX   = GC_SPD_MAX,
   parameter int SPD_STEP  = GC_SPD_STEP,
   parameter int OVER_HOLD = GC_OVER_HOLD
) (
   input  logic               clk3,
   input  logic               reset,
   input  logic               btn_jump,
   input  logic               btn_pause,
   input  logic               collide,
   input  logic [SCORE_W-1:0] score,
   output logic               start,
   output logic               pause,
   output logic               clr_n,
   output logic               game_over,
   output logic [SPD_W-1:0]   speed,
   output logic [SCORE_W-1:0] high_score,
   output logic [1:0]         state
);

   localparam int HOLD_W = $clog2(OVER_HOLD + 1);
   localparam int THR_W  = SCORE_W + 1;

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD);
   localparam logic [SPD_W-1:0]  SPD_B    = SPD_W'(SPD_BASE);
   localparam logic [SPD_W-1:0]  SPD_M    = SPD_W'(SPD_MAX);
   localparam logic [THR_W-1:0]  THR_STEP = THR_W'(SPD_STEP);

   gstate_e             state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [THR_W-1:0]    thr_q, thr_d;
   logic [SPD_W-1:0]    spd_q, spd_d;
   logic [SCORE_W-1:0]  hs_q, hs_d;
   logic                clr_n_q, clr_n_d;
   logic                restart;
   logic                jump_rise;
   logic                pause_rise;

   btn_edge u_jump_edge (
      .clk3   (clk3),
      .reset  (reset),
      .btn_i  (btn_jump),
      .rise_o (jump_rise)
   );

   btn_edge u_pause_edge (
      .clk3   (clk3),
      .reset  (reset),
      .btn_i  (btn_pause),
      .rise_o (pause_rise)
   );

   always_ff @(posedge clk3 or posedge reset) begin
      if (reset) begin
         state_q <= GS_IDLE;
         hold_q  <= '0;
         thr_q   <= '0;
         spd_q   <= SPD_B;
         hs_q    <= '0;
         clr_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         thr_q   <= thr_d;
         spd_q   <= spd_d;
         hs_q    <= hs_d;
         clr_n_q <= clr_n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      unique case (state_q)
         GS_IDLE: begin
            if (jump_rise) begin
               state_d = GS_RUN;
               restart = 1'b1;
            end
         end
         GS_RUN: begin
            // collision outranks a same-cycle pause press
            if (collide)         state_d = GS_OVER;
            else if (pause_rise) state_d = GS_PAUSED;
         end
         GS_PAUSED: begin
            if (pause_rise) state_d = GS_RUN;
         end
         GS_OVER: begin
            if (jump_rise && hold_q == HOLD_MAX) begin
               state_d = GS_RUN;
               restart = 1'b1;
            end
         end
         default: state_d = GS_IDLE;
      endcase
   end

   always_comb begin
      hold_d  = '0;
      spd_d   = spd_q;
      thr_d   = thr_q;
      hs_d    = hs_q;
      clr_n_d = ~restart;

      if (state_q == GS_OVER) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      end

      if (restart) begin
         spd_d = SPD_B;
         thr_d = THR_STEP;
      end else if (state_q == GS_RUN && {1'b0, score} >= thr_q
                   && spd_q < SPD_M) begin
         spd_d = spd_q + 1'b1;
         thr_d = thr_q + THR_STEP;
      end

      if (state_q == GS_RUN && state_d == GS_OVER && score > hs_q) begin
         hs_d = score;
      end
   end

   assign start      = (state_q == GS_RUN) || (state_q == GS_PAUSED);
   assign pause      = (state_q == GS_PAUSED);
   assign game_over  = (state_q == GS_OVER);
   assign clr_n      = clr_n_q;
   assign speed      = spd_q;
   assign high_score = hs_q;
   assign state      = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for the game sequencer.
module tb_game_ctrl;

   logic       clk3 = 1'b0;
   logic       reset;
   logic       btn_jump;
   logic       btn_pause;
   logic       collide;
   logic [9:0] score;
   logic       start;
   logic       pause;
   logic       clr_n;
   logic       game_over;
   logic [3:0] speed;
   logic [9:0] high_score;
   logic [1:0] state;

   int total = 0;
   int bad = 0;

   always #5 clk3 = ~clk3;

   game_ctrl dut (
      .clk3       (clk3),
      .reset      (reset),
      .btn_jump   (btn_jump),
      .btn_pause  (btn_pause),
      .collide    (collide),
      .score      (score),
      .start      (start),
      .pause      (pause),
      .clr_n      (clr_n),
      .game_over  (game_over),
      .speed      (speed),
      .high_score (high_score),
      .state      (state)
   );

   task automatic tick();
      @(posedge clk3);
      #1;
   endtask

   task automatic restart_from_over();
      score = 10'd0;
      btn_jump = 1'b0;
      repeat (31) tick();
      btn_jump = 1'b1;
      tick();
      btn_jump = 1'b0;
      total++;
      if (state !== 2'd1) begin
         bad++;
         $display("FAIL restart_state got=%0d exp=1", state);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      btn_jump = 1'b1;
      btn_pause = 1'b0;
      collide = 1'b0;
      score = 10'd0;
      tick();
      total++;
      if ({state, start, pause, clr_n, game_over} !== 6'b00_0010) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=000010",
                  {state, start, pause, clr_n, game_over});
      end
      total++;
      if (speed !== 4'd1 || high_score !== 10'd0) begin
         bad++;
         $display("FAIL reset_regs got spd=%0d hs=%0d exp 1 0",
                  speed, high_score);
      end
      reset = 1'b0;
      repeat (3) tick();
      total++;
      if (state !== 2'd0 || start !== 1'b0) begin
         bad++;
         $display("FAIL held_no_start got st=%0d start=%0d exp 0 0",
                  state, start);
      end
      btn_jump = 1'b0;
      tick();
      btn_jump = 1'b1;
      tick();
      total++;
      if (state !== 2'd1 || start !== 1'b1 || clr_n !== 1'b0) begin
         bad++;
         $display("FAIL idle_run got st=%0d start=%0d clr_n=%0d exp 1 1 0",
                  state, start, clr_n);
      end
      btn_jump = 1'b0;
      tick();
      total++;
      if (clr_n !== 1'b1 || state !== 2'd1) begin
         bad++;
         $display("FAIL clr_pulse got clr_n=%0d st=%0d exp 1 1",
                  clr_n, state);
      end
   endtask

   task automatic test_pause();
      btn_pause = 1'b1;
      tick();
      btn_pause = 1'b0;
      total++;
      if (state !== 2'd2 || pause !== 1'b1 || start !== 1'b1) begin
         bad++;
         $display("FAIL pause_enter got st=%0d pause=%0d exp 2 1",
                  state, pause);
      end
      collide = 1'b1;
      tick();
      collide = 1'b0;
      btn_jump = 1'b1;
      tick();
      btn_jump = 1'b0;
      tick();
      total++;
      if (state !== 2'd2) begin
         bad++;
         $display("FAIL pause_ignore got=%0d exp=2", state);
      end
      btn_pause = 1'b1;
      tick();
      btn_pause = 1'b0;
      total++;
      if (state !== 2'd1 || pause !== 1'b0) begin
         bad++;
         $display("FAIL pause_exit got st=%0d pause=%0d exp 1 0",
                  state, pause);
      end
   endtask

   task automatic test_over_hold();
      score = 10'd80;
      collide = 1'b1;
      tick();
      collide = 1'b0;
      score = 10'd0;
      total++;
      if (state !== 2'd3 || game_over !== 1'b1 || start !== 1'b0
          || high_score !== 10'd80) begin
         bad++;
         $display("FAIL over_entry got st=%0d go=%0d hs=%0d exp 3 1 80",
                  state, game_over, high_score);
      end
      for (int f = 0; f <= 30; f++) begin
         btn_jump = (f == 5 || f == 29);
         btn_pause = (f == 10);
         tick();
         total++;
         if (state !== 2'd3) begin
            bad++;
            $display("FAIL over_hold f=%0d got=%0d exp=3", f, state);
         end
      end
      btn_pause = 1'b0;
      btn_jump = 1'b1;
      tick();
      btn_jump = 1'b0;
      total++;
      if (state !== 2'd1 || clr_n !== 1'b0 || speed !== 4'd1) begin
         bad++;
         $display("FAIL over_restart got st=%0d clr_n=%0d spd=%0d exp 1 0 1",
                  state, clr_n, speed);
      end
      tick();
      total++;
      if (clr_n !== 1'b1) begin
         bad++;
         $display("FAIL over_clr got=%0d exp=1", clr_n);
      end
   endtask

   task automatic test_collide_pause();
      score = 10'd120;
      collide = 1'b1;
      btn_pause = 1'b1;
      tick();
      collide = 1'b0;
      btn_pause = 1'b0;
      total++;
      if (state !== 2'd3 || game_over !== 1'b1 || high_score !== 10'd120) begin
         bad++;
         $display("FAIL col_win got st=%0d go=%0d hs=%0d exp 3 1 120",
                  state, game_over, high_score);
      end
      restart_from_over();
      score = 10'd60;
      collide = 1'b1;
      tick();
      collide = 1'b0;
      total++;
      if (state !== 2'd3 || high_score !== 10'd120) begin
         bad++;
         $display("FAIL hs_keep got st=%0d hs=%0d exp 3 120",
                  state, high_score);
      end
      restart_from_over();
      score = 10'd120;
      collide = 1'b1;
      tick();
      collide = 1'b0;
      total++;
      if (high_score !== 10'd120) begin
         bad++;
         $display("FAIL hs_equal got=%0d exp=120", high_score);
      end
      restart_from_over();
   endtask

   task automatic test_speed_ramp();
      for (int s = 0; s <= 500; s++) begin
         score = 10'(s);
         tick();
         if (s == 49 || s == 50 || s == 99 || s == 100 || s == 349
             || s == 350 || s == 400 || s == 500) begin
            int exp;
            exp = (s >= 350) ? 8 : 1 + s / 50;
            total++;
            if (speed !== 4'(exp)) begin
               bad++;
               $display("FAIL ramp s=%0d got=%0d exp=%0d", s, speed, exp);
            end
         end
      end
   endtask

   task automatic test_reset_paused();
      collide = 1'b1;
      tick();
      collide = 1'b0;
      total++;
      if (high_score !== 10'd500 || speed !== 4'd8) begin
         bad++;
         $display("FAIL over_hold_spd got hs=%0d spd=%0d exp 500 8",
                  high_score, speed);
      end
      restart_from_over();
      for (int s = 0; s <= 200; s++) begin
         score = 10'(s);
         tick();
      end
      btn_pause = 1'b1;
      tick();
      btn_pause = 1'b0;
      score = 10'd300;
      tick();
      total++;
      if (state !== 2'd2 || speed !== 4'd5) begin
         bad++;
         $display("FAIL paused_spd got st=%0d spd=%0d exp 2 5", state, speed);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (state !== 2'd0 || start !== 1'b0 || pause !== 1'b0
          || speed !== 4'd1 || high_score !== 10'd0) begin
         bad++;
         $display("FAIL async_rst got st=%0d start=%0d pause=%0d spd=%0d hs=%0d exp 0 0 0 1 0",
                  state, start, pause, speed, high_score);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_pause();
      test_over_hold();
      test_collide_pause();
      test_speed_ramp();
      test_reset_paused();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
